// File: rtl/sys_array_lane_alu.sv
// Per-lane ADD/SUB/SAT/MAX against a per-packet constant on an AXI4-Stream.
// Two-stage pipeline feeding a FWFT FIFO; s_axis_tready is credit-exact.
module sys_array_lane_alu #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_FIFO_DEPTH       = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [1:0]                      ctrl_mode,
    input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [31:0]                     stat_pkt_count,
    output logic [31:0]                     stat_sat_count
);
    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int LW = C_LANE_WIDTH;
    localparam int KW = DW / 8;
    localparam int NL = DW / LW;
    localparam int LB = LW / 8;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(C_FIFO_DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_SAT = 2'd2,
        MODE_MAX = 2'd3
    } mode_e;

    logic          acc;
    logic          pop;
    logic          pkt_start;
    mode_e         lat_mode;
    mode_e         cur_mode;
    logic [LW-1:0] lat_const;
    logic [LW-1:0] cur_const;

    assign acc       = s_axis_tvalid & s_axis_tready;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign cur_mode  = pkt_start ? mode_e'(ctrl_mode) : lat_mode;
    assign cur_const = pkt_start ? ctrl_constant : lat_const;

    // ctrl is captured on the first beat of a packet and held until tlast
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_start <= 1'b1;
            lat_mode  <= MODE_ADD;
            lat_const <= '0;
        end else if (acc) begin
            pkt_start <= s_axis_tlast;
            lat_mode  <= cur_mode;
            lat_const <= cur_const;
        end
    end

    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic [KW-1:0] s1_keep;
    logic          s1_last;
    mode_e         s1_mode;
    logic [LW-1:0] s1_const;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_keep  <= '0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_ADD;
            s1_const <= '0;
        end else begin
            s1_valid <= acc;
            if (acc) begin
                s1_data  <= s_axis_tdata;
                s1_keep  <= s_axis_tkeep;
                s1_last  <= s_axis_tlast;
                s1_mode  <= cur_mode;
                s1_const <= cur_const;
            end
        end
    end

    logic [DW-1:0] res;
    logic [NL-1:0] lane_sat;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic [LW-1:0] a;
        logic [LW:0]   sum;
        logic          kept;
        logic [LW-1:0] r;
        logic          s;

        assign a    = s1_data[i*LW +: LW];
        assign sum  = {1'b0, a} + {1'b0, s1_const};
        assign kept = &s1_keep[i*LB +: LB];

        always_comb begin
            r = a;
            s = 1'b0;
            if (kept) begin
                unique case (s1_mode)
                    MODE_ADD: r = sum[LW-1:0];
                    MODE_SUB: r = a - s1_const;
                    MODE_SAT: begin
                        r = sum[LW] ? '1 : sum[LW-1:0];
                        s = sum[LW];
                    end
                    MODE_MAX: r = (a > s1_const) ? a : s1_const;
                endcase
            end
        end

        assign res[i*LW +: LW] = r;
        assign lane_sat[i]     = s;
    end

    logic          s2_valid;
    logic [DW-1:0] s2_data;
    logic [KW-1:0] s2_keep;
    logic          s2_last;
    logic          s2_sat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_keep  <= '0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= res;
                s2_keep <= s1_keep;
                s2_last <= s1_last;
                s2_sat  <= |lane_sat;
            end
        end
    end

    logic [DW-1:0] mem_data [C_FIFO_DEPTH];
    logic [KW-1:0] mem_keep [C_FIFO_DEPTH];
    logic          mem_last [C_FIFO_DEPTH];
    logic          mem_sat  [C_FIFO_DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [AW-1:0] rd_idx;

    assign rd_idx = rd_ptr[AW-1:0];

    always_ff @(posedge aclk) begin
        if (s2_valid) begin
            mem_data[wr_ptr[AW-1:0]] <= s2_data;
            mem_keep[wr_ptr[AW-1:0]] <= s2_keep;
            mem_last[wr_ptr[AW-1:0]] <= s2_last;
            mem_sat[wr_ptr[AW-1:0]]  <= s2_sat;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (s2_valid) wr_ptr <= wr_ptr + ONE;
            if (pop)      rd_ptr <= rd_ptr + ONE;
        end
    end

    assign m_axis_tvalid = (wr_ptr != rd_ptr);
    assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_idx] : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? mem_keep[rd_idx] : '0;
    assign m_axis_tlast  = m_axis_tvalid & mem_last[rd_idx];

    // credits cover beats still in S1/S2, so the FIFO never overflows
    logic [CW-1:0] c_cnt;
    logic [CW-1:0] c_next;

    assign c_next = c_cnt + (acc ? ONE : '0) - (pop ? ONE : '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            c_cnt          <= '0;
            s_axis_tready  <= 1'b0;
            stat_pkt_count <= '0;
            stat_sat_count <= '0;
        end else begin
            c_cnt         <= c_next;
            s_axis_tready <= (c_next < DEPTH);
            if (pop && mem_last[rd_idx]) stat_pkt_count <= stat_pkt_count + 32'd1;
            if (pop && mem_sat[rd_idx])  stat_sat_count <= stat_sat_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_sys_array_lane_alu.sv
// Directed and random checks of sys_array_lane_alu against a queue-based
// per-packet lane model.
module tb_sys_array_lane_alu;
    localparam int DW = 512;
    localparam int W  = 32;
    localparam int N  = DW / W;
    localparam int KW = DW / 8;
    localparam int KB = W / 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic [1:0]    ctrl_mode = 2'd0;
    logic [W-1:0]  ctrl_constant = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [31:0]   stat_pkt_count;
    logic [31:0]   stat_sat_count;

    sys_array_lane_alu #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_LANE_WIDTH      (W),
        .C_FIFO_DEPTH      (32)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ctrl_mode     (ctrl_mode),
        .ctrl_constant (ctrl_constant),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .stat_pkt_count(stat_pkt_count),
        .stat_sat_count(stat_sat_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        bit            s;
    } beat_t;

    beat_t       q[$];
    int          errors = 0;
    int          checks = 0;
    int          popped = 0;
    int unsigned exp_pkt = 0;
    int unsigned exp_sat = 0;
    bit          m_pkt_start = 1'b1;
    logic [1:0]  m_mode = 2'd0;
    logic [W-1:0] m_const = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the packet's latched operation lane by lane.
    task automatic model_accept();
        beat_t b;
        if (m_pkt_start) begin
            m_mode  = ctrl_mode;
            m_const = ctrl_constant;
        end
        b.d = s_axis_tdata;
        b.k = s_axis_tkeep;
        b.l = s_axis_tlast;
        b.s = 1'b0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] a;
            logic [W:0]   s;
            a = s_axis_tdata[i*W +: W];
            if (&s_axis_tkeep[i*KB +: KB]) begin
                case (m_mode)
                    2'd0: b.d[i*W +: W] = a + m_const;
                    2'd1: b.d[i*W +: W] = a - m_const;
                    2'd2: begin
                        s = {1'b0, a} + {1'b0, m_const};
                        if (s > {1'b0, {W{1'b1}}}) begin
                            b.d[i*W +: W] = {W{1'b1}};
                            b.s = 1'b1;
                        end else begin
                            b.d[i*W +: W] = s[W-1:0];
                        end
                    end
                    default: b.d[i*W +: W] = (a > m_const) ? a : m_const;
                endcase
            end
        end
        q.push_back(b);
        m_pkt_start = s_axis_tlast;
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            popped++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat observed=%0h expected=none",
                       m_axis_tdata);
            end else begin
                beat_t b;
                b = q.pop_front();
                chk("tdata", m_axis_tdata, b.d);
                chk("tkeep", DW'(m_axis_tkeep), DW'(b.k));
                chk("tlast", DW'(m_axis_tlast), DW'(b.l));
                exp_pkt += 32'(b.l);
                exp_sat += 32'(b.s);
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l);
        bit done = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                model_accept();
                done = 1'b1;
            end
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        chk("send_accepted", DW'(done), DW'(1));
    endtask

    task automatic stream(input int nb, input int maxc, input bit rnd,
                          output int acc);
        bit have = 1'b0;
        acc = 0;
        for (int t = 0; t < maxc && acc < nb; t++) begin
            if (!have) begin
                for (int i = 0; i < DW / 32; i++)
                    s_axis_tdata[i*32 +: 32] = $urandom;
                if ($urandom % 4 == 0) begin
                    for (int i = 0; i < KW / 32; i++)
                        s_axis_tkeep[i*32 +: 32] = $urandom;
                end else begin
                    s_axis_tkeep = '1;
                end
                s_axis_tlast = ($urandom % 4 == 0);
                have = 1'b1;
            end
            s_axis_tvalid = rnd ? 1'($urandom) : 1'b1;
            if (rnd) begin
                m_axis_tready = 1'($urandom);
                if ($urandom % 8 == 0) begin
                    ctrl_mode     = 2'($urandom);
                    ctrl_constant = W'($urandom);
                end
            end
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                model_accept();
                acc++;
                have = 1'b0;
            end
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        m_axis_tready = 1'b1;
        for (int t = 0; t < 3000 && q.size() != 0; t++) begin
            @(posedge aclk);
            #1;
        end
        repeat (3) begin
            @(posedge aclk);
            #1;
        end
        chk({tag, "_queue_empty"}, DW'(q.size()), DW'(0));
        chk({tag, "_tvalid_low"}, DW'(m_axis_tvalid), DW'(0));
        chk({tag, "_pkt_count"}, DW'(stat_pkt_count), DW'(exp_pkt));
        chk({tag, "_sat_count"}, DW'(stat_sat_count), DW'(exp_sat));
    endtask

    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic [KW-1:0] k;
    int            acc;
    int            p0;

    initial begin
        // reset state
        #1 aresetn = 1'b0;
        #1;
        chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
        chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_m_tlast", DW'(m_axis_tlast), DW'(0));
        chk("rst_pkt", DW'(stat_pkt_count), DW'(0));
        chk("rst_sat", DW'(stat_sat_count), DW'(0));
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("tready_after_release", DW'(s_axis_tready), DW'(1));

        // ADD const 5 over 0xFFFFFFFE, two-cycle latency
        ctrl_mode     = 2'd0;
        ctrl_constant = 32'd5;
        m_axis_tready = 1'b0;
        send_beat({N{32'hFFFF_FFFE}}, '1, 1'b1);
        chk("add_lat_k", DW'(m_axis_tvalid), DW'(0));
        @(posedge aclk);
        #1;
        chk("add_lat_k1", DW'(m_axis_tvalid), DW'(0));
        @(posedge aclk);
        #1;
        chk("add_lat_k2", DW'(m_axis_tvalid), DW'(1));
        chk("add_data", m_axis_tdata, {N{32'h0000_0003}});
        drain("add");
        chk("add_pkt_one", DW'(stat_pkt_count), DW'(1));
        chk("add_sat_zero", DW'(stat_sat_count), DW'(0));

        // SAT const 0x10, then same beat with saturating lanes masked
        ctrl_mode     = 2'd2;
        ctrl_constant = 32'h10;
        for (int i = 0; i < N; i++)
            d[i*W +: W] = (i % 2 == 0) ? 32'hFFFF_FFF5 : 32'h0000_0001;
        for (int i = 0; i < N; i++)
            e[i*W +: W] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0011;
        m_axis_tready = 1'b0;
        send_beat(d, '1, 1'b1);
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        chk("sat_data", m_axis_tdata, e);
        drain("sat");
        chk("sat_count_one", DW'(stat_sat_count), DW'(1));
        for (int i = 0; i < N; i++)
            k[i*KB +: KB] = (i % 2 == 0) ? '0 : '1;
        send_beat(d, k, 1'b1);
        drain("sat_masked");
        chk("sat_masked_no_incr", DW'(stat_sat_count), DW'(1));

        // mode latch: SUB 1 for whole packet despite mid-packet change
        ctrl_mode     = 2'd1;
        ctrl_constant = 32'd1;
        m_axis_tready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            send_beat({N{32'd10}}, '1, b == 3);
            ctrl_mode     = 2'd3;
            ctrl_constant = 32'd9;
        end
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        chk("latch_sub_first", m_axis_tdata, {N{32'd9}});
        drain("latch_sub");
        for (int i = 0; i < N; i++)
            d[i*W +: W] = (i % 2 == 0) ? 32'd3 : 32'd20;
        for (int i = 0; i < N; i++)
            e[i*W +: W] = (i % 2 == 0) ? 32'd9 : 32'd20;
        m_axis_tready = 1'b0;
        send_beat(d, '1, 1'b1);
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        chk("latch_max", m_axis_tdata, e);
        drain("latch_max");

        // backpressure: fill to depth, one pop frees exactly one credit
        p0 = popped;
        m_axis_tready = 1'b0;
        stream(40, 60, 1'b0, acc);
        chk("bp_accepted_32", DW'(acc), DW'(32));
        chk("bp_tready_low", DW'(s_axis_tready), DW'(0));
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        chk("bp_tready_after_pop", DW'(s_axis_tready), DW'(1));
        stream(8, 10, 1'b0, acc);
        chk("bp_one_more", DW'(acc), DW'(1));
        chk("bp_tready_full_again", DW'(s_axis_tready), DW'(0));
        drain("bp");
        chk("bp_popped_33", DW'(popped - p0), DW'(33));

        // random valid/ready with per-packet mode changes
        stream(1000, 20000, 1'b1, acc);
        chk("rand_accepted", DW'(acc), DW'(1000));
        drain("rand");

        // reset with beats in flight
        m_axis_tready = 1'b0;
        stream(10, 30, 1'b0, acc);
        chk("inflight_10", DW'(acc), DW'(10));
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tready", DW'(s_axis_tready), DW'(0));
        chk("mid_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("mid_rst_tdata", m_axis_tdata, '0);
        chk("mid_rst_pkt", DW'(stat_pkt_count), DW'(0));
        chk("mid_rst_sat", DW'(stat_sat_count), DW'(0));
        q.delete();
        m_pkt_start = 1'b1;
        exp_pkt     = 0;
        exp_sat     = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        p0            = popped;
        ctrl_mode     = 2'd0;
        ctrl_constant = 32'd7;
        m_axis_tready = 1'b1;
        send_beat({N{32'd100}}, '1, 1'b0);
        send_beat({N{32'd200}}, '1, 1'b1);
        drain("post_rst");
        chk("post_rst_popped_2", DW'(popped - p0), DW'(2));
        chk("post_rst_pkt_one", DW'(stat_pkt_count), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
